// File: rtl/l2_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_arbiter_if
// Bundle of every handshake between the shared L2 front end, the per-core L1
// video caches and the framebuffer BRAM.
//   Core side : req_en, req_w, req_addr, req_wdata (flattened, core i at
//               [i*W +: W]), req_rdata, req_ready, invalidate, inv_addr,
//               invalidated
//   BRAM side : fb_en, fb_w, fb_addr, fb_din, fb_dout, fb_ready
// Modports:
//   master - the arbiter (drives ready/invalidate/fb command)
//   slave  - the environment: L1 caches plus framebuffer BRAM
// ---------------------------------------------------------------------------
interface l2_arbiter_if #(
  parameter int NCORES = 4,
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32
);
  logic [NCORES-1:0]        req_en;
  logic [NCORES-1:0]        req_w;
  logic [NCORES*ADDR_W-1:0] req_addr;
  logic [NCORES*WORD_W-1:0] req_wdata;
  logic [WORD_W-1:0]        req_rdata;
  logic [NCORES-1:0]        req_ready;
  logic [NCORES-1:0]        invalidate;
  logic [ADDR_W-1:0]        inv_addr;
  logic [NCORES-1:0]        invalidated;
  logic                     fb_en;
  logic                     fb_w;
  logic [ADDR_W-1:0]        fb_addr;
  logic [WORD_W-1:0]        fb_din;
  logic [WORD_W-1:0]        fb_dout;
  logic                     fb_ready;

  modport master (
    input  req_en, req_w, req_addr, req_wdata, invalidated, fb_dout, fb_ready,
    output req_rdata, req_ready, invalidate, inv_addr, fb_en, fb_w, fb_addr, fb_din
  );

  modport slave (
    output req_en, req_w, req_addr, req_wdata, invalidated, fb_dout, fb_ready,
    input  req_rdata, req_ready, invalidate, inv_addr, fb_en, fb_w, fb_addr, fb_din
  );
endinterface

// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
// Shared L2 front end for the video path. Round-robin arbitrates line reads
// (refills) and write-throughs from NCORES L1 caches, performs the granted
// access on the framebuffer port, and before every write invalidates the
// line in all other cores' L1s.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset; abandons any access in flight
//   bus   - l2_arbiter_if.master: core request/response, invalidation
//           handshake and framebuffer command/response
// All outputs are registered.
// ---------------------------------------------------------------------------
module l2_arbiter #(
  parameter int NCORES = 4,
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  l2_arbiter_if.master  bus
);

  localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [2:0] {IDLE, RD, INV, WR, RESP} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    rr_reg;
  logic [IDX_W-1:0]    g_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_W-1:0]   wdata_reg;
  logic [NCORES-1:0]   ack_reg;

  logic [WORD_W-1:0]   req_rdata_reg;
  logic [NCORES-1:0]   req_ready_reg;
  logic [NCORES-1:0]   invalidate_reg;
  logic [ADDR_W-1:0]   inv_addr_reg;
  logic                fb_en_reg;
  logic                fb_w_reg;
  logic [ADDR_W-1:0]   fb_addr_reg;
  logic [WORD_W-1:0]   fb_din_reg;

  // Per-core views of the flattened address/data buses.
  logic [ADDR_W-1:0]   addr_arr  [NCORES];
  logic [WORD_W-1:0]   wdata_arr [NCORES];

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.req_wdata[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Round-robin scan: first requester at or after rr_reg, wrapping.
  logic             found_next;
  logic [IDX_W-1:0] grant_next;

  always_comb begin
    int idx;
    logic [IDX_W-1:0] idx_k;
    found_next = 1'b0;
    grant_next = '0;
    idx        = 0;
    idx_k      = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NCORES) begin
        idx = idx - NCORES;
      end
      idx_k = IDX_W'(idx);
      if (!found_next && bus.req_en[idx_k]) begin
        found_next = 1'b1;
        grant_next = idx_k;
      end
    end
  end

  logic [NCORES-1:0] one_vec;
  logic [NCORES-1:0] grant_onehot;
  logic [NCORES-1:0] g_onehot;
  logic [NCORES-1:0] ack_all;
  logic              inv_done;
  logic [IDX_W-1:0]  rr_adv;

  assign one_vec      = {{(NCORES-1){1'b0}}, 1'b1};
  assign grant_onehot = one_vec << grant_next;
  assign g_onehot     = one_vec << g_reg;
  // An ack arriving in the same cycle counts, and acks from the writer
  // itself (never targeted) are masked off.
  assign ack_all      = ack_reg | (bus.invalidated & ~g_onehot);
  assign inv_done     = &(ack_all | g_onehot);
  assign rr_adv       = (g_reg == IDX_W'(NCORES-1)) ? '0 : g_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_reg         <= '0;
      g_reg          <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ack_reg        <= '0;
      req_rdata_reg  <= '0;
      req_ready_reg  <= '0;
      invalidate_reg <= '0;
      inv_addr_reg   <= '0;
      fb_en_reg      <= 1'b0;
      fb_w_reg       <= 1'b0;
      fb_addr_reg    <= '0;
      fb_din_reg     <= '0;
    end else begin
      req_ready_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (found_next) begin
            g_reg     <= grant_next;
            addr_reg  <= addr_arr[grant_next];
            wdata_reg <= wdata_arr[grant_next];
            if (bus.req_w[grant_next]) begin
              state_reg      <= INV;
              invalidate_reg <= ~grant_onehot;
              inv_addr_reg   <= addr_arr[grant_next];
              ack_reg        <= '0;
            end else begin
              state_reg   <= RD;
              fb_en_reg   <= 1'b1;
              fb_w_reg    <= 1'b0;
              fb_addr_reg <= addr_arr[grant_next];
            end
          end
        end
        RD: begin
          if (bus.fb_ready) begin
            fb_en_reg     <= 1'b0;
            req_rdata_reg <= bus.fb_dout;
            // A withdrawn request gets no ready pulse but still moves rr on.
            if (bus.req_en[g_reg]) begin
              req_ready_reg <= g_onehot;
              state_reg     <= RESP;
            end else begin
              rr_reg    <= rr_adv;
              state_reg <= IDLE;
            end
          end
        end
        INV: begin
          if (inv_done) begin
            invalidate_reg <= '0;
            ack_reg        <= '0;
            state_reg      <= WR;
            fb_en_reg      <= 1'b1;
            fb_w_reg       <= 1'b1;
            fb_addr_reg    <= addr_reg;
            fb_din_reg     <= wdata_reg;
          end else begin
            ack_reg <= ack_all;
          end
        end
        WR: begin
          if (bus.fb_ready) begin
            fb_en_reg <= 1'b0;
            fb_w_reg  <= 1'b0;
            if (bus.req_en[g_reg]) begin
              req_ready_reg <= g_onehot;
              state_reg     <= RESP;
            end else begin
              rr_reg    <= rr_adv;
              state_reg <= IDLE;
            end
          end
        end
        RESP: begin
          rr_reg    <= rr_adv;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_rdata  = req_rdata_reg;
  assign bus.req_ready  = req_ready_reg;
  assign bus.invalidate = invalidate_reg;
  assign bus.inv_addr   = inv_addr_reg;
  assign bus.fb_en      = fb_en_reg;
  assign bus.fb_w       = fb_w_reg;
  assign bus.fb_addr    = fb_addr_reg;
  assign bus.fb_din     = fb_din_reg;

endmodule

// File: tb/tb_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_arbiter
// Directed bench for l2_arbiter: a framebuffer BRAM model with programmable
// latency, an L1 invalidation responder with per-core ack delay, and a
// scoreboard of expected completions (core, read data) filled as requests
// are driven and drained as req_ready pulses appear.
// ---------------------------------------------------------------------------
module tb_l2_arbiter;
  localparam int NC = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_arbiter_if #(.NCORES(NC), .ADDR_W(AW), .WORD_W(DW)) bus ();

  l2_arbiter #(.NCORES(NC), .ADDR_W(AW), .WORD_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NC-1:0] onehot;
    bit            is_rd;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // ---------------- framebuffer BRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            fb_lat = 1;
  int            fb_cnt = 0;
  int            fb_done_cnt = 0;
  bit            preloaded = 1'b0;
  logic [AW-1:0] wr_addr_seen = '0;
  logic [DW-1:0] wr_data_seen = '0;

  always @(negedge clk) begin
    if (!preloaded) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
      mem[12'h010] = 32'hDEADBEEF;
      for (int c = 0; c < NC; c++) mem[12'h200 + c] = 32'h1000_0000 + c;
      preloaded = 1'b1;
    end
    if (bus.fb_en === 1'b1 && bus.fb_ready !== 1'b1) begin
      fb_cnt++;
      if (fb_cnt >= fb_lat) begin
        bus.fb_ready = 1'b1;
        fb_done_cnt++;
        if (bus.fb_w === 1'b1) begin
          mem[bus.fb_addr] = bus.fb_din;
          wr_addr_seen = bus.fb_addr;
          wr_data_seen = bus.fb_din;
        end else begin
          bus.fb_dout = mem[bus.fb_addr];
        end
      end else begin
        bus.fb_ready = 1'b0;
      end
    end else begin
      bus.fb_ready = 1'b0;
      bus.fb_dout  = '0;
      fb_cnt       = 0;
    end
  end

  // ---------------- L1 invalidation responder ----------------
  int ack_dly [NC];
  int icnt    [NC];

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (bus.invalidate[i] === 1'b1) begin
        bus.invalidated[i] = (icnt[i] >= ack_dly[i]);
        icnt[i]++;
      end else begin
        bus.invalidated[i] = 1'b0;
        icnt[i] = 0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int            st_fb_en, st_inv, st_inv_bad, st_overlap;
  logic [NC-1:0] exp_inv;
  logic [AW-1:0] exp_inv_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    st_fb_en = 0; st_inv = 0; st_inv_bad = 0; st_overlap = 0;
  endtask

  task automatic sample();
    if (bus.fb_en === 1'b1) st_fb_en++;
    if (bus.invalidate !== '0) begin
      st_inv++;
      if (bus.invalidate !== exp_inv || bus.inv_addr !== exp_inv_addr) st_inv_bad++;
      if (bus.fb_en === 1'b1) st_overlap++;
    end
  endtask

  task automatic push(input int c, input bit rd, input logic [DW-1:0] d);
    exp_t e;
    e.onehot = NC'(1) << c;
    e.is_rd  = rd;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_w[c]               = w;
    bus.req_addr[c*AW +: AW]   = a;
    bus.req_wdata[c*DW +: DW]  = d;
    bus.req_en[c]              = 1'b1;
  endtask

  // Waits (bounded) for a ready pulse, then compares it to the scoreboard.
  task automatic wait_ready(input int budget, output int n);
    bit   got;
    exp_t e;
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      sample();
      if (bus.req_ready !== '0) got = 1'b1;
    end
    chk("ready_seen", 64'(got), 64'd1);
    if (got) begin
      if (sb.size() == 0) begin
        chk("ready_unexpected", 64'(bus.req_ready), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("txn: ready=%b rdata=0x%08h (expect core mask %b)", bus.req_ready, bus.req_rdata, e.onehot);
        chk("ready_core", 64'(bus.req_ready), 64'(e.onehot));
        if (e.is_rd) chk("rdata", 64'(bus.req_rdata), 64'(e.data));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int cnt;
    int done0;
    bit hit;

    bus.req_en    = '0;
    bus.req_w     = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    exp_inv       = '0;
    exp_inv_addr  = '0;
    ack_dly       = '{0, 0, 0, 0};
    clr_stats();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  64'(bus.req_ready),  64'd0);
    chk("rst_req_rdata",  64'(bus.req_rdata),  64'd0);
    chk("rst_invalidate", 64'(bus.invalidate), 64'd0);
    chk("rst_inv_addr",   64'(bus.inv_addr),   64'd0);
    chk("rst_fb_en",      64'(bus.fb_en),      64'd0);
    chk("rst_fb_w",       64'(bus.fb_w),       64'd0);
    chk("rst_fb_addr",    64'(bus.fb_addr),    64'd0);
    chk("rst_fb_din",     64'(bus.fb_din),     64'd0);

    // Round robin: all cores read continuously from reset -> 0,1,2,3,0
    fb_lat = 1;
    for (int c = 0; c < NC; c++) begin
      drive_req(c, 1'b0, AW'(32'h200 + c), '0);
      push(c, 1'b1, DW'(32'h1000_0000 + c));
    end
    push(0, 1'b1, 32'h1000_0000);
    rst_n = 1'b1;
    wait_ready(20, n);
    chk("rd_min_latency", 64'(n), 64'd2);
    for (int k = 1; k < 5; k++) wait_ready(20, n);
    bus.req_en = '0;
    @(negedge clk);

    // Read: core1, 0x010, fb_ready two cycles after fb_en
    clr_stats();
    fb_lat = 2;
    drive_req(1, 1'b0, 12'h010, '0);
    push(1, 1'b1, 32'hDEADBEEF);
    wait_ready(20, n);
    bus.req_en[1] = 1'b0;
    chk("rd_latency",      64'(n),        64'd3);
    chk("rd_fb_en_cycles", 64'(st_fb_en), 64'd2);
    chk("rd_no_inval",     64'(st_inv),   64'd0);
    @(negedge clk);
    chk("ready_one_cycle", 64'(bus.req_ready), 64'd0);
    chk("rdata_held",      64'(bus.req_rdata), 64'hDEADBEEF);

    // Write with invalidation: core2, core1 acks three cycles late
    fb_lat       = 1;
    ack_dly      = '{0, 3, 0, 0};
    exp_inv      = 4'b1011;
    exp_inv_addr = 12'h020;
    clr_stats();
    drive_req(2, 1'b1, 12'h020, 32'h12345678);
    push(2, 1'b0, '0);
    wait_ready(30, n);
    bus.req_en[2] = 1'b0;
    chk("wr_inv_cycles",   64'(st_inv),       64'd4);
    chk("wr_inv_value",    64'(st_inv_bad),   64'd0);
    chk("wr_no_overlap",   64'(st_overlap),   64'd0);
    chk("wr_latency",      64'(n),            64'd6);
    chk("wr_fb_en_cycles", 64'(st_fb_en),     64'd1);
    chk("wr_fb_addr",      64'(wr_addr_seen), 64'h020);
    chk("wr_fb_din",       64'(wr_data_seen), 64'h12345678);
    @(negedge clk);
    ack_dly = '{0, 0, 0, 0};
    drive_req(3, 1'b0, 12'h020, '0);
    push(3, 1'b1, 32'h12345678);
    wait_ready(20, n);
    bus.req_en[3] = 1'b0;
    @(negedge clk);

    // Same line, same cycle: core0 write before core3 read (rr=0)
    exp_inv      = 4'b1110;
    exp_inv_addr = 12'h100;
    clr_stats();
    drive_req(0, 1'b1, 12'h100, 32'hAAAA5555);
    drive_req(3, 1'b0, 12'h100, '0);
    push(0, 1'b0, '0);
    push(3, 1'b1, 32'hAAAA5555);
    wait_ready(30, n);
    bus.req_en[0] = 1'b0;
    chk("wr0_inv_cycles", 64'(st_inv),     64'd1);
    chk("wr0_inv_value",  64'(st_inv_bad), 64'd0);
    wait_ready(30, n);
    bus.req_en[3] = 1'b0;
    @(negedge clk);

    // Withdrawn request: core1 drops req_en during RD, core2 waiting
    fb_lat = 3;
    done0  = fb_done_cnt;
    drive_req(1, 1'b0, 12'h201, '0);
    drive_req(2, 1'b0, 12'h202, '0);
    push(2, 1'b1, 32'h1000_0002);
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (bus.fb_en === 1'b1) hit = 1'b1;
    end
    chk("wd_fb_started", 64'(hit),         64'd1);
    chk("wd_fb_addr",    64'(bus.fb_addr), 64'h201);
    bus.req_en[1] = 1'b0;
    wait_ready(40, n);
    bus.req_en[2] = 1'b0;
    chk("wd_fb_accesses", 64'(fb_done_cnt - done0), 64'd2);
    @(negedge clk);

    // Reset during WR: core3 writes (rr=3 beforehand), slow BRAM
    fb_lat       = 10;
    exp_inv      = 4'b0111;
    exp_inv_addr = 12'h030;
    drive_req(3, 1'b1, 12'h030, 32'h0BADF00D);
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (bus.fb_en === 1'b1 && bus.fb_w === 1'b1) hit = 1'b1;
    end
    chk("rst_wr_started", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fb_en",      64'(bus.fb_en),      64'd0);
    chk("arst_fb_w",       64'(bus.fb_w),       64'd0);
    chk("arst_fb_addr",    64'(bus.fb_addr),    64'd0);
    chk("arst_fb_din",     64'(bus.fb_din),     64'd0);
    chk("arst_req_rdata",  64'(bus.req_rdata),  64'd0);
    chk("arst_inv_addr",   64'(bus.inv_addr),   64'd0);
    chk("arst_invalidate", 64'(bus.invalidate), 64'd0);
    bus.req_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.req_ready !== '0) cnt++;
    end
    chk("rst_no_ready", 64'(cnt), 64'd0);
    // rr back at 0: core1 must win over core3
    fb_lat = 1;
    drive_req(1, 1'b0, 12'h201, '0);
    drive_req(3, 1'b0, 12'h203, '0);
    push(1, 1'b1, 32'h1000_0001);
    push(3, 1'b1, 32'h1000_0003);
    wait_ready(20, n);
    bus.req_en[1] = 1'b0;
    wait_ready(20, n);
    bus.req_en[3] = 1'b0;
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
